multicycle_control: RTL and testbench

//  Multi-cycle main control FSM; drives the ALUOp interface consumed by the ALU-select decoder.

---
 rtl/multicycle_control.sv | 216 +++++++++++++++++++++
 tb/tb_multicycle_control.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM for a multi-cycle datapath.
// It steps through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK using the
// IR opcode, and drives the datapath mux selects, the PC/IR/register write
// enables and the memory strobes. Memory accesses wait on mem_ready.
// Ports:
//   clk, reset_n                 clock (rising edge), async active-low reset
//   opcode[5:0]                  IR[31:26]
//   alu_zero, alu_neg            ALU result flags, used for branch decisions
//   mem_ready                    the current memory access completes this cycle
//   ALUOp[1:0]                   00 ADD, 01 SUB, 10 decode by opcode
//   alu_src_a/b, pc_source       datapath mux selects
//   pc_write, ir_write, i_or_d   PC/IR load enables and memory address select
//   mem_read, mem_write          memory strobes
//   reg_write, reg_dst,
//   mem_to_reg                   register-file write controls
//   illegal                      one-cycle pulse in DECODE for an unknown opcode
//   state[3:0]                   current state (debug)
//   instr_count[CNT_W-1:0]       number of instructions fetched, wraps
// Everything except state and instr_count is decoded combinationally from the
// current state and the inputs, so reset drops the strobes asynchronously.
module multicycle_control #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [5:0]       opcode,
    input  logic             alu_zero,
    input  logic             alu_neg,
    input  logic             mem_ready,
    output logic [1:0]       ALUOp,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       pc_source,
    output logic             pc_write,
    output logic             ir_write,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_I   = 4'd4,
        S_WB_ALU   = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_WB_MEM   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic is_rtype, is_itype, is_load, is_store, is_branch, is_jump, is_noop;
    logic abs_addr, br_taken;

    // Opcode classification.
    always_comb begin
        is_rtype  = (opcode[5:3] == 3'b010);
        is_itype  = ((opcode >= 6'b110010) && (opcode <= 6'b110111))
                    || (opcode == 6'b111001) || (opcode == 6'b111010);
        is_load   = (opcode == 6'b111011) || (opcode == 6'b111101);
        is_store  = (opcode == 6'b111100) || (opcode == 6'b111110);
        is_branch = (opcode[5:2] == 4'b1000);
        is_jump   = (opcode == 6'b000001);
        is_noop   = (opcode == 6'b000000);
        // LWI/SWI address from a zero base instead of regA
        abs_addr  = (opcode == 6'b111011) || (opcode == 6'b111100);
    end

    // Branch condition: BEQ, BNE, BLT, BLE selected by the low opcode bits.
    always_comb begin
        br_taken = 1'b0;
        unique case (opcode[1:0])
            2'b00:   br_taken = alu_zero;
            2'b01:   br_taken = ~alu_zero;
            2'b10:   br_taken = alu_neg;
            default: br_taken = alu_neg | alu_zero;
        endcase
    end

    // Next state, counter update and control outputs.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        ALUOp      = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        pc_source  = 2'b00;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        illegal    = 1'b0;

        case (state_q)
            S_RESET: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    count_d  = count_q + CNT_W'(1);
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                // precompute the branch target into ALUOut
                alu_src_b = 2'b11;
                if (is_rtype) begin
                    state_d = S_EXEC_R;
                end else if (is_itype) begin
                    state_d = S_EXEC_I;
                end else if (is_load || is_store) begin
                    state_d = S_MEM_ADDR;
                end else if (is_branch) begin
                    state_d = S_BRANCH;
                end else if (is_jump) begin
                    state_d = S_JUMP;
                end else begin
                    illegal = ~is_noop;
                    state_d = S_FETCH;
                end
            end
            S_EXEC_R: begin
                alu_src_a = 2'b01;
                ALUOp     = 2'b10;
                state_d   = S_WB_ALU;
            end
            S_EXEC_I: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                ALUOp     = 2'b10;
                state_d   = S_WB_ALU;
            end
            S_WB_ALU: begin
                reg_write = 1'b1;
                reg_dst   = is_rtype;
                state_d   = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a = abs_addr ? 2'b10 : 2'b01;
                alu_src_b = 2'b10;
                state_d   = is_load ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) begin
                    state_d = S_WB_MEM;
                end
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) begin
                    state_d = S_FETCH;
                end
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 2'b01;
                ALUOp     = 2'b01;
                pc_source = 2'b01;
                pc_write  = br_taken;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pc_source = 2'b10;
                pc_write  = 1'b1;
                state_d   = S_FETCH;
            end
            default: begin
                // unused encodings recover to FETCH with everything idle
                state_d = S_FETCH;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_RESET;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign state       = 4'(state_q);
    assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: each instruction is expanded into the list of
// cycles the control unit should produce, then replayed against the DUT.
// A second instance with a 3-bit counter shares all inputs to exercise wrap.
module tb_multicycle_control;

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned SCNT_W = 3;

    typedef struct packed {
        logic [1:0] aluop;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [1:0] pc_src;
        logic       pc_write;
        logic       ir_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       illegal;
    } ctl_t;

    typedef struct {
        logic [3:0] st;
        ctl_t       ctl;
        logic       ready;
        logic       z;
        logic       n;
        logic       use_op;
        logic       fetch_done;
    } step_t;

    typedef enum int {C_NOOP, C_JUMP, C_BRANCH, C_RTYPE, C_ITYPE, C_LOAD, C_STORE, C_ILLEGAL} cls_e;

    logic              clk;
    logic              reset_n;
    logic [5:0]        opcode;
    logic              alu_zero, alu_neg, mem_ready;
    logic [1:0]        ALUOp, alu_src_a, alu_src_b, pc_source;
    logic              pc_write, ir_write, i_or_d, mem_read, mem_write;
    logic              reg_write, reg_dst, mem_to_reg, illegal;
    logic [3:0]        state;
    logic [CNT_W-1:0]  instr_count;

    logic [1:0]        s_aluop, s_src_a, s_src_b, s_pc_source;
    logic              s_pc_write, s_ir_write, s_i_or_d, s_mem_read, s_mem_write;
    logic              s_reg_write, s_reg_dst, s_mem_to_reg, s_illegal;
    logic [3:0]        s_state;
    logic [SCNT_W-1:0] s_instr_count;

    ctl_t              obs;
    int unsigned       n_tests = 0;
    int unsigned       n_fail  = 0;
    int unsigned       model_cnt = 0;

    assign obs = {ALUOp, alu_src_a, alu_src_b, pc_source, pc_write, ir_write, i_or_d,
                  mem_read, mem_write, reg_write, reg_dst, mem_to_reg, illegal};

    multicycle_control #(.CNT_W(CNT_W)) u_dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .alu_zero(alu_zero),
        .alu_neg(alu_neg), .mem_ready(mem_ready), .ALUOp(ALUOp),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
        .pc_write(pc_write), .ir_write(ir_write), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .illegal(illegal),
        .state(state), .instr_count(instr_count)
    );

    multicycle_control #(.CNT_W(SCNT_W)) u_dut_small (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .alu_zero(alu_zero),
        .alu_neg(alu_neg), .mem_ready(mem_ready), .ALUOp(s_aluop),
        .alu_src_a(s_src_a), .alu_src_b(s_src_b), .pc_source(s_pc_source),
        .pc_write(s_pc_write), .ir_write(s_ir_write), .i_or_d(s_i_or_d),
        .mem_read(s_mem_read), .mem_write(s_mem_write), .reg_write(s_reg_write),
        .reg_dst(s_reg_dst), .mem_to_reg(s_mem_to_reg), .illegal(s_illegal),
        .state(s_state), .instr_count(s_instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic cls_e classify(input logic [5:0] op);
        int unsigned v;
        v = 32'(op);
        if (v >= 16 && v <= 23)                        return C_RTYPE;
        if ((v >= 50 && v <= 55) || v == 57 || v == 58) return C_ITYPE;
        if (v == 59 || v == 61)                        return C_LOAD;
        if (v == 60 || v == 62)                        return C_STORE;
        if (v >= 32 && v <= 35)                        return C_BRANCH;
        if (v == 1)                                    return C_JUMP;
        if (v == 0)                                    return C_NOOP;
        return C_ILLEGAL;
    endfunction

    function automatic logic taken(input logic [5:0] op, input logic z, input logic n);
        case (32'(op))
            32:      return z;          // BEQ
            33:      return !z;         // BNE
            34:      return n;          // BLT
            default: return n || z;     // BLE
        endcase
    endfunction

    function automatic step_t mk(input logic [3:0] st, input ctl_t c, input logic ready,
                                 input logic use_op, input logic done);
        step_t s;
        s.st         = st;
        s.ctl        = c;
        s.ready      = ready;
        s.z          = 1'($urandom_range(0, 1));
        s.n          = 1'($urandom_range(0, 1));
        s.use_op     = use_op;
        s.fetch_done = done;
        return s;
    endfunction

    // Drive one cycle, check it at the falling edge, then advance past the rising edge.
    task automatic exec_step(input step_t s, input logic [5:0] op);
        opcode    = s.use_op ? op : 6'($urandom_range(0, 63));
        mem_ready = s.ready;
        alu_zero  = s.z;
        alu_neg   = s.n;
        @(negedge clk);
        check("state",       32'(state),         32'(s.st));
        check("controls",    32'(obs),           32'(s.ctl));
        check("instr_count", 32'(instr_count),   32'(CNT_W'(model_cnt)));
        check("count_wrap3", 32'(s_instr_count), 32'(SCNT_W'(model_cnt)));
        check("state_w3",    32'(s_state),       32'(s.st));
        @(posedge clk);
        #1;
        if (s.fetch_done) model_cnt++;
    endtask

    // One idle cycle in RESET after release, then the edge into FETCH.
    task automatic release_reset();
        reset_n   = 1'b1;
        mem_ready = 1'($urandom_range(0, 1));
        opcode    = 6'($urandom_range(0, 63));
        @(negedge clk);
        check("rel_state",    32'(state), 32'd0);
        check("rel_controls", 32'(obs),   32'd0);
        @(posedge clk);
        #1;
    endtask

    // Expand one instruction into expected cycles and replay them.
    task automatic run_instr(input logic [5:0] op, input int fwait, input int mwait,
                             input logic z, input logic n, input bit abort);
        step_t q[$];
        step_t s;
        ctl_t  c;
        cls_e  k;
        k = classify(op);

        for (int i = 0; i < fwait; i++) begin
            c = '0; c.mem_read = 1'b1; c.src_b = 2'b01;
            q.push_back(mk(4'd1, c, 1'b0, 1'b0, 1'b0));
        end
        c = '0; c.mem_read = 1'b1; c.src_b = 2'b01; c.ir_write = 1'b1; c.pc_write = 1'b1;
        q.push_back(mk(4'd1, c, 1'b1, 1'b0, 1'b1));

        c = '0; c.src_b = 2'b11; c.illegal = (k == C_ILLEGAL);
        q.push_back(mk(4'd2, c, 1'($urandom_range(0, 1)), 1'b1, 1'b0));

        case (k)
            C_RTYPE, C_ITYPE: begin
                c = '0; c.src_a = 2'b01; c.aluop = 2'b10;
                c.src_b = (k == C_RTYPE) ? 2'b00 : 2'b10;
                q.push_back(mk((k == C_RTYPE) ? 4'd3 : 4'd4, c, 1'($urandom_range(0, 1)), 1'b1, 1'b0));
                c = '0; c.reg_write = 1'b1; c.reg_dst = (k == C_RTYPE);
                q.push_back(mk(4'd5, c, 1'($urandom_range(0, 1)), 1'b1, 1'b0));
            end
            C_LOAD, C_STORE: begin
                c = '0; c.src_b = 2'b10;
                c.src_a = (op == 6'd59 || op == 6'd60) ? 2'b10 : 2'b01;
                q.push_back(mk(4'd6, c, 1'($urandom_range(0, 1)), 1'b1, 1'b0));
                if (!abort) begin
                    c = '0; c.i_or_d = 1'b1;
                    if (k == C_LOAD) c.mem_read = 1'b1; else c.mem_write = 1'b1;
                    for (int i = 0; i <= mwait; i++)
                        q.push_back(mk((k == C_LOAD) ? 4'd7 : 4'd8, c, (i == mwait), 1'b1, 1'b0));
                    if (k == C_LOAD) begin
                        c = '0; c.reg_write = 1'b1; c.mem_to_reg = 1'b1;
                        q.push_back(mk(4'd9, c, 1'($urandom_range(0, 1)), 1'b1, 1'b0));
                    end
                end
            end
            C_BRANCH: begin
                c = '0; c.src_a = 2'b01; c.aluop = 2'b01; c.pc_src = 2'b01;
                c.pc_write = taken(op, z, n);
                s = mk(4'd10, c, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
                s.z = z;
                s.n = n;
                q.push_back(s);
            end
            C_JUMP: begin
                c = '0; c.pc_src = 2'b10; c.pc_write = 1'b1;
                q.push_back(mk(4'd11, c, 1'($urandom_range(0, 1)), 1'b1, 1'b0));
            end
            default: ;
        endcase

        foreach (q[i]) exec_step(q[i], op);

        if (abort) begin
            // sit in MEM_WR without mem_ready, then pull reset mid-cycle
            opcode    = op;
            mem_ready = 1'b0;
            @(negedge clk);
            check("abort_state",     32'(state),     32'd8);
            check("abort_mem_write", 32'(mem_write), 32'd1);
            #2;
            reset_n = 1'b0;
            #1;
            check("abort_drop_write", 32'(mem_write), 32'd0);
            check("abort_drop_state", 32'(state),     32'd0);
            @(posedge clk);
            #1;
            model_cnt = 0;
            check("abort_count", 32'(instr_count), 32'd0);
            release_reset();
        end
    endtask

    logic [5:0] legal_ops [15] = '{6'd0, 6'd1, 6'd16, 6'd23, 6'd50, 6'd55, 6'd57, 6'd58,
                                   6'd59, 6'd60, 6'd61, 6'd62, 6'd32, 6'd33, 6'd35};

    initial begin
        logic [5:0] op;
        reset_n   = 1'b0;
        opcode    = 6'd0;
        alu_zero  = 1'b0;
        alu_neg   = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;

        // reset held for three cycles with random inputs
        for (int i = 0; i < 3; i++) begin
            opcode    = 6'($urandom_range(0, 63));
            mem_ready = 1'($urandom_range(0, 1));
            alu_zero  = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("reset_state",    32'(state),       32'd0);
            check("reset_controls", 32'(obs),         32'd0);
            check("reset_count",    32'(instr_count), 32'd0);
            @(posedge clk);
            #1;
        end
        release_reset();

        // directed cases
        run_instr(6'b010010, 0, 0, 1'b0, 1'b0, 1'b0);   // ADD
        run_instr(6'b111101, 0, 3, 1'b0, 1'b0, 1'b0);   // LW with 3 wait cycles
        run_instr(6'b100000, 0, 0, 1'b1, 1'b0, 1'b0);   // BEQ taken
        run_instr(6'b100000, 0, 0, 1'b0, 1'b0, 1'b0);   // BEQ not taken
        run_instr(6'b100011, 0, 0, 1'b1, 1'b0, 1'b0);   // BLE via zero
        run_instr(6'b001111, 0, 0, 1'b0, 1'b0, 1'b0);   // illegal
        run_instr(6'b111100, 2, 0, 1'b0, 1'b0, 1'b0);   // SWI with fetch wait
        run_instr(6'b111110, 0, 0, 1'b0, 1'b0, 1'b1);   // SW, reset during MEM_WR

        // random instruction stream
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) op = 6'($urandom_range(0, 63));
            else                           op = legal_ops[$urandom_range(0, 14)];
            run_instr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
